// File: rtl/seq_encoder16_pkg.sv
// +-----------------------------------------------------------------+
// | seq_encoder_pkg : shared types and sizes for seq_encoder16       |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package seq_encoder_pkg;
  localparam int N  = 16;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

`default_nettype wire

// File: rtl/seq_encoder16_if.sv
// +-----------------------------------------------------------------+
// | seq_encoder16_if : request/code handshake bundle                 |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

interface seq_encoder16_if;
  import seq_encoder_pkg::*;

  logic          en;
  logic          load;
  logic [0:N-1]  w;
  logic          ready;
  logic [CW-1:0] y;
  logic          valid;
  logic          busy;
  logic          done;
  logic [CW:0]   count;

  modport master (
    output en, load, w, ready,
    input  y, valid, busy, done, count
  );

  modport slave (
    input  en, load, w, ready,
    output y, valid, busy, done, count
  );
endinterface

`default_nettype wire

// File: rtl/seq_encoder16_prienc16.sv
// +-----------------------------------------------------------------+
// | prienc16 : combinational 16-line priority encoder, lowest wins   |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module prienc16
  import seq_encoder_pkg::*;
(
  input  logic [0:N-1]  req,
  output logic [CW-1:0] code,
  output logic          any
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    code = '0;
    any  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        code = CW'(i);
        any  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_encoder16.sv
// +-----------------------------------------------------------------+
// | seq_encoder16 : sequential 16-to-4 encoder with valid/ready out  |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module seq_encoder16
  import seq_encoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  seq_encoder16_if.slave      bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EMIT = EMIT;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]    state;
  logic [0:N-1]  pending;
  logic [CW:0]   count;

  logic [CW-1:0] code;
  logic          any;
  logic [0:N-1]  pending_cleared;
  logic          xfer;

  prienc16 u_prienc (
    .req  (pending),
    .code (code),
    .any  (any)
  );

  always_comb begin
    pending_cleared       = pending;
    pending_cleared[code] = 1'b0;
  end

  assign bus.y     = code;
  assign bus.valid = bus.en && (state == ST_EMIT);
  assign bus.busy  = (state != ST_IDLE);
  assign bus.done  = bus.en && (state == ST_DONE);
  assign bus.count = count;

  assign xfer = bus.valid && bus.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pending <= '0;
      count   <= '0;
    end else if (bus.en) begin
      case (state)
        ST_IDLE: begin
          if (bus.load) begin
            pending <= bus.w;
            count   <= '0;
            state   <= (|bus.w) ? ST_EMIT : ST_DONE;
          end
        end
        ST_EMIT: begin
          if (xfer) begin
            pending <= pending_cleared;
            count   <= count + 1'b1;
            // Only the bit being transferred was left: this is the last code.
            if (pending_cleared == '0 || !any) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_encoder16.sv
// +-----------------------------------------------------------------+
// | tb_seq_encoder16 : random + directed check against a code queue  |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_seq_encoder16;
  import seq_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_encoder16_if bus ();

  seq_encoder16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference: phase 0 idle, 1 emitting, 2 finished; q holds untransferred codes.
  int phase   = 0;
  int q[$];
  int m_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic en, input logic load, input logic [0:15] w, input logic ready);
    bus.en    = en;
    bus.load  = load;
    bus.w     = w;
    bus.ready = ready;
    #1;
    chk("y",     32'(bus.y),     (q.size() > 0) ? q[0] : 0);
    chk("valid", 32'(bus.valid), 32'(en && phase == 1));
    chk("busy",  32'(bus.busy),  32'(phase != 0));
    chk("done",  32'(bus.done),  32'(en && phase == 2));
    chk("count", 32'(bus.count), m_count);
    @(posedge clk);
    if (en) begin
      case (phase)
        0: if (load) begin
          q.delete();
          for (int i = 0; i < 16; i++) if (w[i]) q.push_back(i);
          m_count = 0;
          phase   = (q.size() > 0) ? 1 : 2;
        end
        1: if (ready) begin
          void'(q.pop_front());
          m_count++;
          if (q.size() == 0) phase = 2;
        end
        default: phase = 0;
      endcase
    end
    @(negedge clk);
  endtask

  function automatic logic [0:15] bits(input int a, input int b, input int c);
    logic [0:15] v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  task automatic drain(input logic rnd);
    for (int k = 0; k < 200 && phase != 0; k++) begin
      if (rnd) step($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                    16'($urandom), $urandom_range(0, 3) != 0);
      else     step(1'b1, 1'b0, 16'($urandom), 1'b1);
    end
    chk("drain_busy", 32'(bus.busy), 32'(0));
  endtask

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.w = '0; bus.ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, '0, 1'b1);

    // Sparse vector: bits 0 and 15.
    step(1'b1, 1'b1, bits(0, 15, -1), 1'b1);
    chk("sparse_y0", 32'(bus.y), 32'(0));
    drain(1'b0);
    chk("sparse_cnt", 32'(bus.count), 32'(2));

    // Full vector.
    step(1'b1, 1'b1, 16'hFFFF, 1'b1);
    drain(1'b0);
    chk("full_cnt", 32'(bus.count), 32'(16));

    // Backpressure with stray loads that must be ignored.
    step(1'b1, 1'b1, bits(3, 5, -1), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'hFFFF, 1'b0);
    drain(1'b0);
    chk("bp_cnt", 32'(bus.count), 32'(2));

    // Zero load, then a Load pulse during DONE.
    step(1'b1, 1'b1, '0, 1'b1);
    step(1'b1, 1'b1, 16'hFFFF, 1'b1);
    chk("zero_cnt", 32'(bus.count), 32'(0));
    chk("zero_idle", 32'(bus.busy), 32'(0));

    // Enable stall after first transfer.
    step(1'b1, 1'b1, bits(2, 9, 14), 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'hFFFF, 1'b1);
    chk("stall_y", 32'(bus.y), 32'(9));
    drain(1'b0);
    chk("stall_cnt", 32'(bus.count), 32'(3));

    // Asynchronous reset mid-EMIT.
    step(1'b1, 1'b1, 16'hFFFF, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_y",     32'(bus.y),     32'(0));
    chk("rst_valid", 32'(bus.valid), 32'(0));
    chk("rst_busy",  32'(bus.busy),  32'(0));
    chk("rst_done",  32'(bus.done),  32'(0));
    chk("rst_count", 32'(bus.count), 32'(0));
    q.delete(); phase = 0; m_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'($urandom), 1'b1);

    // Randomized vectors with random enable, backpressure and stray loads.
    for (int v = 0; v < 60; v++) begin
      logic [0:15] wv;
      wv = 16'($urandom);
      if (v % 3 == 0) wv = wv & 16'($urandom) & 16'($urandom);
      if (v % 11 == 0) wv = '0;
      step(1'b1, 1'b1, wv, $urandom_range(0, 1) != 0);
      drain(1'b1);
      step($urandom_range(0, 1) != 0, 1'b0, 16'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_encoder16.md
# seq_encoder16

Sequential 16-to-4 encoder: the inverse of the lab's 4-to-16 one-hot decoder. It captures a 16-bit request vector W[0:15] and emits the 4-bit index of every set bit, lowest index first, one code per accepted transfer on a Valid/Ready handshake. It sits between a multi-hot event source and any consumer that takes binary line numbers. Bit ordering matches the decoder: code i corresponds to W[i].

## Interface
- N, 16: number of request lines; fixed at 16 in this revision.
- CW, 4: code width, log2(N).
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- En  in  1  global enable; 0 freezes all state.
- Load  in  1  capture request vector; honoured only in IDLE with En=1.
- W  in  [0:15]  request vector sampled on Load.
- Ready  in  1  consumer can accept Y this cycle.
- Y  out  [3:0]  index of lowest set pending bit.
- Valid  out  1  Y holds a code awaiting transfer.
- Busy  out  1  state is not IDLE.
- Done  out  1  one-cycle pulse after the last code transfers, or after a Load of zero.
- Count  out  [4:0]  codes transferred since the last accepted Load (0..16).

## Operation
- Registers: state, pending[0:15], Count.
- States:
  - IDLE: Busy=0, Valid=0.
    - En=1 and Load=1: pending<=W, Count<=0.
    - Next state is EMIT if W≠0, else DONE.
  - EMIT:
    - Valid=En.
    - Y = priority_encode(pending), lowest index wins.
    - Transfer occurs when Valid=1 and Ready=1 at the rising edge. On transfer:
      - Clear pending[Y].
      - Count<=Count+1.
      - If this was the last set bit, go to DONE.
    - Without Ready: hold everything.
  - DONE:
    - Done=1, Valid=0.
    - Next cycle (En=1): IDLE.
    - Load in DONE is ignored.
- En=0: state, pending and Count hold; Valid and Done forced 0; Y holds its combinational value.
- Load outside IDLE is ignored; W is don't-care unless a Load is accepted.
- Y is derived combinationally from the pending register, so Y=0 whenever pending=0.
- Count saturation: Count never exceeds 16 because at most 16 bits are set; no wrap.
- Asynchronous Resetn=0 at any time, including mid-EMIT:
  - Immediately state=IDLE, pending=0, Count=0.
  - Outputs become Y=0, Valid=0, Busy=0, Done=0.
  - Untransferred codes are discarded.

## Timing
- Load accepted at edge k: Valid=1 with the first code from cycle k+1.
- With Ready held high, back-to-back transfers occur with no bubble: n set bits give n Valid cycles (k+1..k+n), and Done pulses at k+n+1.
- Load of W=0: Done pulses at k+1; Valid never asserts.
- Y and Valid are stable while Valid=1 and Ready=0; the code does not change until transferred.
- Earliest new Load: the cycle after Done (state IDLE), so throughput is n+2 cycles per vector.
- Ready is sampled only at rising edges; there is no combinational path from Ready to Valid or Y.

## Structure
- Shared package seq_encoder_pkg holds:
  - The state enum {IDLE, EMIT, DONE}.
  - Constants N=16 and CW=4.
- One sub-module, prienc16: a combinational priority encoder.
  - Input: pending[0:15].
  - Outputs: code[3:0] and any.
  - Lowest index wins; code=0 when any=0.
- Top level holds the FSM, the pending clear-on-transfer logic and Count.

## Test plan
- Reset: assert Resetn=0 during EMIT with pending=16'hFFFF → Y=0, Valid=0, Busy=0, Count=0 immediately, without a clock edge; after release, no Valid until a new Load.
- Sparse vector: Load W with bits 0 and 15 set, Ready=1 → Y=0 then Y=15 on consecutive Valid cycles, Done pulse next cycle, Count=2.
- Full vector: Load W=16'hFFFF, Ready=1 → Y=0,1,…,15 on 16 consecutive cycles, Done at cycle 17, Count=16.
- Backpressure: Load bits 3 and 5, Ready=0 for 3 cycles → Valid=1 with Y=3 held for 3 cycles, then Y=3, Y=5 transfer, Done, Count=2.
- Zero and ignored loads: Load W=0 → Done at k+1, Valid never 1, Count=0. Load pulses during EMIT and DONE → pending unchanged.
- Enable stall: Load bits 2, 9 and 14; drop En for 4 cycles after the first transfer → Valid=0 and Count=1 held. Re-enable → Y=9, then Y=14, Done, Count=3.
